// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl
// Purpose  : Central stall sequencer for the five-stage pipeline. Merges the
//            decode load-use stall request with a counted multi-cycle execute
//            sequence (div, madd/msub), drives the per-stage stall vector,
//            pulses done when the sequence completes and keeps a free-running
//            stall-cycle performance counter.
// Ports    : clk            pipeline clock
//            rst            asynchronous active-high reset
//            stallreq_id_i  decode load-use stall request (same cycle)
//            mc_start_i     EX requests a multi-cycle sequence
//            mc_cycles_i    sequence length N (0 treated as 1)
//            mc_annul_i     abort current sequence (exception/flush)
//            stall_o        {WB,MEM,EX,ID,IF,PC} stall vector
//            mc_done_o      one-cycle pulse: EX result valid, EX advances
//            mc_busy_o      sequence in RUN
//            mc_cnt_o       remaining RUN cycles (0 outside RUN)
//            stall_cnt_o    cycles with any stall asserted, wraps
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id_i,
  input  logic              mc_start_i,
  input  logic [CNT_W-1:0]  mc_cycles_i,
  input  logic              mc_annul_i,
  output logic [5:0]        stall_o,
  output logic              mc_done_o,
  output logic              mc_busy_o,
  output logic [CNT_W-1:0]  mc_cnt_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  localparam logic [5:0] C_STALL_MC = 6'b001111;  // hold PC/IF/ID/EX
  localparam logic [5:0] C_STALL_ID = 6'b000111;  // hold PC/IF/ID
  localparam logic [5:0] C_STALL_NO = 6'b000000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_len;
  logic               w_mc_stall;
  logic               w_done;
  logic [PERF_W-1:0]  r_stall_cnt;

  // A zero-length request still needs one cycle for EX to produce its result.
  assign w_len = (mc_cycles_i == '0) ? CNT_W'(1) : mc_cycles_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mc_stall  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        // Annul in the start cycle drops the request entirely.
        if (mc_start_i && !mc_annul_i) begin
          w_mc_stall = 1'b1;
          if (w_len == CNT_W'(1)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = w_len - CNT_W'(1);
          end
        end
      end
      S_RUN: begin
        // The current cycle still stalls; annul only cuts the sequence
        // from the next cycle on. New starts are ignored here.
        w_mc_stall = 1'b1;
        if (mc_annul_i) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_DONE: begin
        // Annul here suppresses the pulse so a flushed result never retires.
        w_done      = !mc_annul_i;
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Multi-cycle stall overrides the decode request; the decode request is
  // never latched.
  always_comb begin
    stall_o = C_STALL_NO;
    if (w_mc_stall) begin
      stall_o = C_STALL_MC;
    end else if (stallreq_id_i) begin
      stall_o = C_STALL_ID;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (stall_o != C_STALL_NO) begin
      r_stall_cnt <= r_stall_cnt + PERF_W'(1);
    end
  end

  assign mc_done_o   = w_done;
  assign mc_busy_o   = (r_state == S_RUN);
  assign mc_cnt_o    = (r_state == S_RUN) ? r_cnt : '0;
  assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stall_ctrl
// Purpose  : Self-checking bench for pipe_stall_ctrl. A timeline model tracks
//            each sequence by its start cycle and length; a vector table and
//            directed sequences cover the corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

  localparam int CW = 6;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stallreq_id_i = 1'b0;
  logic          mc_start_i = 1'b0;
  logic [CW-1:0] mc_cycles_i = '0;
  logic          mc_annul_i = 1'b0;
  logic [5:0]    stall_o;
  logic          mc_done_o;
  logic          mc_busy_o;
  logic [CW-1:0] mc_cnt_o;
  logic [PW-1:0] stall_cnt_o;

  pipe_stall_ctrl #(.CNT_W(CW), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst), .stallreq_id_i(stallreq_id_i),
    .mc_start_i(mc_start_i), .mc_cycles_i(mc_cycles_i),
    .mc_annul_i(mc_annul_i), .stall_o(stall_o), .mc_done_o(mc_done_o),
    .mc_busy_o(mc_busy_o), .mc_cnt_o(mc_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Timeline model: sequence occupies stall cycles [m_t, m_t+m_n-1],
  // done at cycle m_t+m_n.
  int cyc = 0;
  bit m_active = 0;
  int m_t = 0;
  int m_n = 0;
  int m_perf = 0;

  // Snapshot of DUT outputs from the latest step.
  logic [5:0]    a_stall;
  logic          a_done, a_busy;
  logic [CW-1:0] a_cnt;
  logic [PW-1:0] a_perf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit st, input int n, input bit an, input bit rq);
    bit mc, busy, done;
    int cnt;
    logic [5:0] e_stall;
    @(negedge clk);
    mc_start_i = st; mc_cycles_i = CW'(n); mc_annul_i = an; stallreq_id_i = rq;
    #2;
    a_stall = stall_o; a_done = mc_done_o; a_busy = mc_busy_o;
    a_cnt = mc_cnt_o; a_perf = stall_cnt_o;
    if (!m_active && st && !an) begin
      m_active = 1; m_t = cyc; m_n = (n % 64 == 0) ? 1 : n % 64;
    end
    mc = 0; busy = 0; done = 0; cnt = 0;
    if (m_active) begin
      if (cyc < m_t + m_n) begin
        mc = 1;
        if (cyc > m_t) begin busy = 1; cnt = m_t + m_n - cyc; end
      end else begin
        done = !an;
      end
    end
    e_stall = mc ? 6'b001111 : (rq ? 6'b000111 : 6'b000000);
    chk("stall_o", a_stall, e_stall);
    chk("mc_done_o", a_done, done);
    chk("mc_busy_o", a_busy, busy);
    chk("mc_cnt_o", a_cnt, cnt);
    chk("stall_cnt_o", a_perf, m_perf);
    if (m_active && ((cyc > m_t && an) || cyc == m_t + m_n)) m_active = 0;
    if (e_stall != 0) m_perf = (m_perf + 1) % (1 << PW);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    mc_start_i = 0; mc_annul_i = 0; stallreq_id_i = 0; mc_cycles_i = '0;
    #1;
    chk("rst_stall", stall_o, 0);
    chk("rst_busy", mc_busy_o, 0);
    chk("rst_cnt", mc_cnt_o, 0);
    chk("rst_done", mc_done_o, 0);
    chk("rst_perf", stall_cnt_o, 0);
    m_active = 0; m_perf = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit st; int n; bit an; bit rq;
    logic [5:0] e_stall; bit e_done; bit e_busy; int e_cnt;
  } vec_t;

  vec_t vt[11];
  int perf0, dones;

  initial begin
    // Vector table, applied from IDLE right after reset.
    vt[0]  = '{0, 0, 0, 0, 6'b000000, 0, 0, 0};
    vt[1]  = '{0, 0, 0, 1, 6'b000111, 0, 0, 0};
    vt[2]  = '{1, 2, 0, 0, 6'b001111, 0, 0, 0};
    vt[3]  = '{1, 5, 0, 1, 6'b001111, 0, 1, 1};  // start ignored in RUN
    vt[4]  = '{0, 0, 0, 1, 6'b000111, 1, 0, 0};  // DONE, decode stall shows
    vt[5]  = '{1, 0, 0, 0, 6'b001111, 0, 0, 0};  // N=0 acts as 1
    vt[6]  = '{1, 3, 0, 0, 6'b000000, 1, 0, 0};  // start in DONE not taken
    vt[7]  = '{1, 3, 1, 0, 6'b000000, 0, 0, 0};  // annul with start
    vt[8]  = '{1, 1, 0, 0, 6'b001111, 0, 0, 0};
    vt[9]  = '{0, 0, 1, 0, 6'b000000, 0, 0, 0};  // annul in DONE
    vt[10] = '{0, 0, 0, 0, 6'b000000, 0, 0, 0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(vt[i].st, vt[i].n, vt[i].an, vt[i].rq);
      chk($sformatf("vec%0d_stall", i), a_stall, vt[i].e_stall);
      chk($sformatf("vec%0d_done", i), a_done, vt[i].e_done);
      chk($sformatf("vec%0d_busy", i), a_busy, vt[i].e_busy);
      chk($sformatf("vec%0d_cnt", i), a_cnt, vt[i].e_cnt);
    end

    // Divide length 34: 34 stall cycles, done at T+34.
    step(0, 0, 0, 0);
    perf0 = stall_cnt_o;
    step(1, 34, 0, 0);
    chk("div_start_stall", a_stall, 6'b001111);
    for (int k = 1; k < 34; k++) begin
      step(0, 0, 0, 0);
      chk("div_cnt", a_cnt, 34 - k);
    end
    step(0, 0, 0, 0);
    chk("div_done", a_done, 1);
    chk("div_done_stall", a_stall, 0);
    chk("div_perf", a_perf, (perf0 + 34) % 256);

    // N=2 and priority with decode request held through a 5-cycle sequence.
    step(1, 2, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("n2_done", a_done, 1);
    step(1, 5, 0, 1);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1);
    chk("pri_run_stall", a_stall, 6'b001111);
    step(0, 0, 0, 1);
    chk("pri_done_stall", a_stall, 6'b000111);
    step(0, 0, 0, 1);
    chk("pri_after_stall", a_stall, 6'b000111);

    // Annul at T+4 of a 10-cycle sequence.
    step(1, 10, 0, 0);
    for (int k = 1; k < 4; k++) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("annul_cycle_stall", a_stall, 6'b001111);
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 0, 0);
      dones += a_done;
    end
    chk("annul_no_done", dones, 0);
    chk("annul_stall_clear", a_stall, 0);

    // Async reset mid-RUN with cnt=20.
    step(1, 21, 0, 0);
    step(0, 0, 0, 0);
    chk("pre_rst_cnt", a_cnt, 20);
    do_reset();
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0);
      dones += a_done;
    end
    chk("post_rst_no_done", dones, 0);

    // Perf counter wrap.
    while (m_perf != 255) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("wrap_full", a_perf, 8'hFF);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("wrap_zero", a_perf, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      step(($urandom % 6) == 0,
           ($urandom % 4 == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 6)),
           ($urandom % 20) == 0,
           ($urandom % 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
